// File: rtl/spi_pkg.sv
// Shared SPI definitions for the slave receiver and the spi_controller master.
// Holds default geometry and the receiver FSM state encoding.
package spi_pkg;

  localparam int SPI_DATA_W      = 8;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop pin synchronizer with registered rise/fall pulses.
// RST_VAL is the pin's idle level so reset never fakes an edge.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
      fall <= ~sync[STAGES-1] & prev;
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: receives MSB-first words on mosi, returns tx_din on miso.
// All pin decisions use synchronized copies; sclk must be slow vs clk.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_bar,
  input  logic              mosi,
  input  logic [DATA_W-1:0] tx_din,
  output logic              miso,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int            CW   = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic                   sclk_unused;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_q;
  logic                   cs_rise;
  logic                   cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_q;
  spi_state_t             state;
  logic [CW-1:0]          cnt;
  logic [DATA_W-1:0]      rx_sh;
  logic [DATA_W-1:0]      tx_sh;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sclk (
    .clk (clk),
    .rst (rst),
    .din (sclk),
    .q   (sclk_unused),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs (
    .clk (clk),
    .rst (rst),
    .din (cs_bar),
    .q   (cs_q),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync <= '0;
    else      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state <= RECV;
            busy  <= 1'b1;
            cnt   <= '0;
            rx_sh <= '0;
            tx_sh <= tx_din;
          end
        end
        RECV: begin
          // a completing bit wins over a simultaneous cs_bar rise
          if (sclk_rise && cnt == LAST) begin
            dout  <= {rx_sh[DATA_W-2:0], mosi_q};
            cnt   <= '0;
            rx_sh <= '0;
            state <= DONE;
            busy  <= 1'b0;
          end else if (cs_rise) begin
            frame_err <= (cnt != '0);
            cnt       <= '0;
            rx_sh     <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (sclk_rise) begin
            cnt   <= cnt + 1'b1;
            rx_sh <= {rx_sh[DATA_W-2:0], mosi_q};
          end else if (sclk_fall && cnt != '0) begin
            // the fall after a word's last bit keeps the fresh reload
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
          end
        end
        DONE: begin
          dout_valid <= 1'b1;
          tx_sh      <= tx_din;
          if (cs_q) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RECV;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign miso = ~cs_q & (state != IDLE) & tx_sh[DATA_W-1];

endmodule
